// File: rtl/spi_xfer_engine.sv
// SPI mode-0 master that streams a byte buffer out MSB first and overwrites each byte in place with the received byte.
// Latency: 16*(clk_div+1)+3 clk per byte, +1 for FINISH; done pulses the cycle after FINISH.
// Backpressure: none. start is ignored while busy. Define SPI_XFER_LOOPBACK_EN to receive from internal mosi instead of miso.
module spi_xfer_engine #(
    parameter int num_bytes = 8192,
    localparam int addr_bits = $clog2(num_bytes)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_bits:0]   xfer_len,
    input  logic [7:0]           clk_div,
    output logic                 busy,
    output logic                 done,
    output logic [addr_bits-1:0] buf_addr,
    output logic [7:0]           buf_wr_val,
    output logic                 buf_wr_en,
    input  logic [7:0]           buf_rd_val,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 cs_n
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, STORE, FINISH} state_t;

    localparam logic [addr_bits-1:0] last_addr = addr_bits'(num_bytes - 1);
    localparam logic [addr_bits-1:0] addr_one  = addr_bits'(1);
    localparam logic [addr_bits:0]   len_one   = (addr_bits + 1)'(1);

    state_t             state, nxt;
    logic [7:0]         clk_div_q;
    logic [7:0]         div_cnt;
    logic [3:0]         hp_cnt;
    logic [addr_bits:0] rem;
    logic [7:0]         tx;
    logic [7:0]         rx;
    logic               tick;
    logic               rx_bit;

    // mosi is always the head of the TX shift register, so it resets and idles low.
    assign mosi = tx[7];
    assign tick = (div_cnt == clk_div_q);

`ifdef SPI_XFER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = tx[7];
`else
    assign rx_bit = miso;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (start && xfer_len != '0) nxt = FETCH;
            FETCH:  nxt = LOAD;
            LOAD:   nxt = SHIFT;
            SHIFT:  if (tick && hp_cnt == 4'd15) nxt = STORE;
            STORE:  nxt = (rem == len_one) ? FINISH : FETCH;
            FINISH: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            buf_addr   <= '0;
            buf_wr_val <= '0;
            buf_wr_en  <= 1'b0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            clk_div_q  <= '0;
            div_cnt    <= '0;
            hp_cnt     <= '0;
            rem        <= '0;
            tx         <= '0;
            rx         <= '0;
        end else begin
            done      <= 1'b0;
            buf_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (xfer_len != '0) begin
                            rem       <= xfer_len;
                            clk_div_q <= clk_div;
                            buf_addr  <= '0;
                            busy      <= 1'b1;
                            cs_n      <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    tx      <= buf_rd_val;
                    div_cnt <= '0;
                    hp_cnt  <= '0;
                    sclk    <= 1'b0;
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        hp_cnt  <= hp_cnt + 4'd1;
                        sclk    <= ~sclk;
                        if (!sclk) rx <= {rx[6:0], rx_bit};
                        else       tx <= {tx[6:0], 1'b0};
                        // Last half-period is a falling edge, so rx already holds all 8 bits.
                        if (hp_cnt == 4'd15) begin
                            buf_wr_en  <= 1'b1;
                            buf_wr_val <= rx;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                STORE: begin
                    if (rem != len_one) begin
                        rem      <= rem - len_one;
                        buf_addr <= (buf_addr == last_addr) ? '0 : buf_addr + addr_one;
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    cs_n <= 1'b1;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: behavioural buffer, SPI slave model and scoreboards for buffer writes and mosi bytes.
module tb_spi_xfer_engine;

    localparam int NB = 8192;
    localparam int AB = $clog2(NB);
`ifdef SPI_XFER_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic [AB:0]   xfer_len = '0;
    logic [7:0]    clk_div = '0;
    logic          busy, done, buf_wr_en, sclk, mosi, miso, cs_n;
    logic [AB-1:0] buf_addr;
    logic [7:0]    buf_wr_val;
    logic [7:0]    buf_rd_val;

    logic [7:0]    mem [NB];

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int cyc = 0, busy_cyc = 0, done_cnt = 0, wr_cnt = 0, rise_cnt = 0;
    int last_rise = 0, period = 0, bitcnt = 0;
    bit cs_low = 1'b0;
    logic prev_sclk = 1'b0;
    logic [7:0] cap = '0;
    logic [2:0] rbit = '0;
    bit echo_mode = 1'b0;
    logic miso_lvl = 1'b0;
    logic [7:0] echo_byte = 8'h5A;

    logic [AB+7:0] exp_wr [$];
    logic [7:0]    exp_mosi [$];

    spi_xfer_engine #(.num_bytes(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .xfer_len(xfer_len), .clk_div(clk_div),
        .busy(busy), .done(done), .buf_addr(buf_addr), .buf_wr_val(buf_wr_val),
        .buf_wr_en(buf_wr_en), .buf_rd_val(buf_rd_val),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    assign miso = echo_mode ? echo_byte[3'd7 - rbit] : miso_lvl;

    // Buffer port B: one-cycle read latency, write in place.
    always @(posedge clk) begin
        buf_rd_val <= mem[buf_addr];
        if (buf_wr_en) mem[buf_addr] = buf_wr_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cnt++;
        if (cs_n === 1'b0) cs_low = 1'b1;
        if (buf_wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_wr.size() == 0) chk("wr_queue_nonempty", exp_wr.size(), 1);
            else begin
                logic [AB+7:0] e;
                e = exp_wr.pop_front();
                chk("wr_addr", buf_addr, e[AB+7:8]);
                chk("wr_data", buf_wr_val, e[7:0]);
            end
        end
        if (rst === 1'b1 || cs_n !== 1'b0) begin
            bitcnt = 0;
            rbit   = '0;
        end else if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            cap       = {cap[6:0], mosi};
            rbit      = rbit + 3'd1;
            bitcnt++;
            rise_cnt++;
            period    = cyc - last_rise;
            last_rise = cyc;
            if (bitcnt == 8) begin
                bitcnt = 0;
                if (exp_mosi.size() == 0) chk("mosi_queue_nonempty", exp_mosi.size(), 1);
                else chk("mosi_byte", cap, exp_mosi.pop_front());
            end
        end
        prev_sclk = sclk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_byte(input int addr, input logic [7:0] txb, input logic [7:0] rxb);
        exp_mosi.push_back(txb);
        exp_wr.push_back({AB'(addr), (LB ? txb : rxb)});
    endtask

    task automatic pulse_start(input int len, input logic [7:0] div);
        xfer_len = (AB + 1)'(len);
        clk_div  = div;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (done_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        int b_busy, b_done, b_wr, b_rise;
        logic [7:0] pat [4];
        bit reached;
        pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h00;

        rst = 1'b1;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", buf_addr, 0);
        chk("rst_wr_val", buf_wr_val, 0);
        chk("rst_wr_en", buf_wr_en, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 1);
        rst = 1'b0;
        step(2);

        // Four bytes, clk_div=1, miso held high.
        for (int i = 0; i < 4; i++) begin
            mem[i] = pat[i];
            expect_byte(i, pat[i], 8'hFF);
        end
        miso_lvl = 1'b1;
        b_busy = busy_cyc; b_done = done_cnt;
        pulse_start(4, 8'd1);
        wait_done("t1_done_seen", 400);
        step(3);
        chk("t1_busy_cycles", busy_cyc - b_busy, 4 * 35 + 1);
        chk("t1_done_pulses", done_cnt - b_done, 1);
        chk("t1_cs_n_idle", cs_n, 1);
        for (int i = 0; i < 4; i++) chk("t1_mem", mem[i], LB ? pat[i] : 8'hFF);

        // Zero-length request.
        cs_low = 1'b0;
        b_wr = wr_cnt; b_busy = busy_cyc;
        pulse_start(0, 8'd3);
        chk("t2_done_next", done, 1);
        step(4);
        chk("t2_cs_low_seen", cs_low, 0);
        chk("t2_wr_cnt", wr_cnt - b_wr, 0);
        chk("t2_busy_cycles", busy_cyc - b_busy, 0);

        // Slave echoes 0x5A, clk_div=0.
        mem[0] = 8'h11; mem[1] = 8'h22;
        expect_byte(0, 8'h11, 8'h5A);
        expect_byte(1, 8'h22, 8'h5A);
        echo_mode = 1'b1;
        pulse_start(2, 8'd0);
        wait_done("t3_done_seen", 200);
        chk("t3_sclk_period", period, 2);
        chk("t3_mem0", mem[0], LB ? 8'h11 : 8'h5A);
        chk("t3_mem1", mem[1], LB ? 8'h22 : 8'h5A);
        echo_mode = 1'b0;

        // start while busy is ignored.
        miso_lvl = 1'b0;
        mem[0] = 8'h81; mem[1] = 8'h7E;
        expect_byte(0, 8'h81, 8'h00);
        expect_byte(1, 8'h7E, 8'h00);
        b_busy = busy_cyc; b_done = done_cnt; b_wr = wr_cnt;
        pulse_start(2, 8'd0);
        step(5);
        pulse_start(5, 8'd3);
        wait_done("t4_done_seen", 200);
        step(10);
        chk("t4_done_pulses", done_cnt - b_done, 1);
        chk("t4_wr_cnt", wr_cnt - b_wr, 2);
        chk("t4_busy_cycles", busy_cyc - b_busy, 2 * 19 + 1);

        // Reset after five sclk rises of byte 0.
        mem[0] = 8'h96; mem[1] = 8'h69;
        b_done = done_cnt; b_wr = wr_cnt; b_rise = rise_cnt;
        reached = 1'b0;
        pulse_start(2, 8'd1);
        for (int i = 0; i < 100; i++) begin
            if (rise_cnt - b_rise >= 5) begin
                reached = 1'b1;
                break;
            end
            step(1);
        end
        chk("t5_rises_reached", reached, 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_cs_n", cs_n, 1);
        chk("t5_sclk", sclk, 0);
        chk("t5_mosi", mosi, 0);
        chk("t5_addr", buf_addr, 0);
        chk("t5_wr_en", buf_wr_en, 0);
        step(3);
        rst = 1'b0;
        step(5);
        chk("t5_mem0", mem[0], 8'h96);
        chk("t5_done_pulses", done_cnt - b_done, 0);
        chk("t5_wr_cnt", wr_cnt - b_wr, 0);

        // Single byte C3 with miso low.
        mem[0] = 8'hC3;
        expect_byte(0, 8'hC3, 8'h00);
        pulse_start(1, 8'd2);
        wait_done("t6_done_seen", 200);
        step(2);
        chk("t6_mem0", mem[0], LB ? 8'hC3 : 8'h00);

        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("mosi_queue_drained", exp_mosi.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_xfer_engine.md
SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 SHALL have parameter num_bytes, default 8192, buffer depth in bytes; addr_bits = $clog2(num_bytes).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle transfer request.
REQ-005 SHALL have port xfer_len  input  addr_bits+1  byte count, 0..num_bytes, sampled on accepted start.
REQ-006 SHALL have port clk_div  input  8  SCLK half-period minus one in clk cycles, sampled on accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until done.
REQ-008 SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 SHALL have port buf_addr  output  addr_bits  buffer port-B address.
REQ-010 SHALL have port buf_wr_val  output  8  received byte to buffer.
REQ-011 SHALL have port buf_wr_en  output  1  buffer write strobe.
REQ-012 SHALL have port buf_rd_val  input  8  buffer read data, valid one cycle after buf_addr is presented.
REQ-013 SHALL have ports sclk output 1, mosi output 1, miso input 1, cs_n output 1 (SPI mode 0, MSB first).

Function
REQ-014 States SHALL be IDLE, FETCH, LOAD, SHIFT, STORE, FINISH.
REQ-015 IDLE: start with xfer_len != 0 SHALL latch xfer_len/clk_div, set buf_addr = 0, assert busy and cs_n=0, go FETCH.
REQ-016 start with xfer_len == 0 SHALL skip buffer and SPI activity and pulse done on the next cycle; cs_n stays 1.
REQ-017 start while busy SHALL be ignored.
REQ-018 FETCH SHALL last one cycle (buffer read latency); LOAD SHALL copy buf_rd_val into the TX shift register and drive mosi = bit 7.
REQ-019 SHIFT SHALL toggle sclk every clk_div+1 cycles, 16 half-periods per byte; sample miso on each rising sclk, shift mosi to next bit on each falling sclk; sclk ends low.
REQ-020 STORE SHALL assert buf_wr_en for exactly one cycle with buf_wr_val = received byte at the current buf_addr (in-place overwrite).
REQ-021 After STORE, if bytes remain, buf_addr SHALL increment (wrapping modulo num_bytes) and go FETCH; else go FINISH.
REQ-022 FINISH SHALL deassert cs_n and busy and pulse done for one cycle, then return to IDLE.
REQ-023 Per-byte latency SHALL be 16*(clk_div+1) + 3 cycles; cs_n SHALL stay low continuously between bytes.
REQ-024 buf_wr_en SHALL never be asserted outside STORE.

Reset
REQ-025 rst SHALL force IDLE immediately, regardless of state.
REQ-026 Reset values: busy=0, done=0, buf_addr=0, buf_wr_val=0, buf_wr_en=0, sclk=0, mosi=0, cs_n=1.
REQ-027 Reset mid-transfer SHALL abandon the byte in flight with no buffer write and no done pulse.

Configuration
REQ-028 With SPI_XFER_LOOPBACK_EN defined, received bits SHALL be taken from internal mosi instead of miso (miso ignored); without it, miso is used and no loopback logic exists.

Verification
REQ-029 Buffer bytes 0..3 = A5,3C,FF,00, xfer_len=4, clk_div=1, miso tied 1 -> mosi bitstreams match bytes MSB first, buffer 0..3 = FF each, done 1 pulse, total 4*35+1 cycles in busy.
REQ-030 xfer_len=0 start -> done next cycle, cs_n never low, buf_wr_en never high.
REQ-031 SPI slave model echoing 0x5A per byte, xfer_len=2, clk_div=0 -> sclk period 2 clk, buffer 0..1 = 5A.
REQ-032 rst asserted after 5 sclk rises of byte 0 -> outputs at reset values same cycle, buffer unchanged, no done.
REQ-033 start re-pulsed while busy -> ignored, transfer count unchanged.
REQ-034 SPI_XFER_LOOPBACK_EN defined, buffer 0 = C3, xfer_len=1 -> buffer 0 reads back C3 regardless of miso.
